// File: rtl/hilo_acc_unit.sv
// HI/LO special-register unit: direct MTHI/MTLO/result writes plus a
// two-cycle pipelined multiply-accumulate on the concatenated {HI,LO} value.
module hilo_acc_unit #(
  parameter int DATA_W = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [2:0]            op,
  input  logic [DATA_W-1:0]     hi_in,
  input  logic [DATA_W-1:0]     lo_in,
  input  logic [2*DATA_W-1:0]   prod,
  output logic [DATA_W-1:0]     hi_out,
  output logic [DATA_W-1:0]     lo_out,
  output logic                  busy
);

  localparam int ACC_W = 2 * DATA_W;

  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              pend_v_q, pend_v_d;
  logic              pend_sub_q, pend_sub_d;
  logic [ACC_W-1:0]  pend_prod_q, pend_prod_d;
  logic [ACC_W-1:0]  acc;

  // Commit value of the pending accumulate; wraps modulo 2^ACC_W.
  always_comb begin
    if (pend_sub_q) acc = {hi_q, lo_q} - pend_prod_q;
    else            acc = {hi_q, lo_q} + pend_prod_q;
  end

  always_comb begin
    hi_d        = hi_q;
    lo_d        = lo_q;
    pend_v_d    = pend_v_q;
    pend_sub_d  = pend_sub_q;
    pend_prod_d = pend_prod_q;
    if (rst) begin
      hi_d        = '0;
      lo_d        = '0;
      pend_v_d    = 1'b0;
      pend_sub_d  = 1'b0;
      pend_prod_d = '0;
    end else if (flush) begin
      pend_v_d = 1'b0;
    end else if (!stall) begin
      if (pend_v_q) begin
        hi_d = acc[ACC_W-1:DATA_W];
        lo_d = acc[DATA_W-1:0];
      end
      pend_v_d = 1'b0;
      // A direct write is younger than the committing accumulate, so it wins
      // only on the half it selects.
      case (op)
        3'b001: hi_d = hi_in;
        3'b010: lo_d = lo_in;
        3'b011: begin
          hi_d = hi_in;
          lo_d = lo_in;
        end
        3'b100, 3'b101: begin
          pend_v_d    = 1'b1;
          pend_sub_d  = op[0];
          pend_prod_d = prod;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    hi_q        <= hi_d;
    lo_q        <= lo_d;
    pend_v_q    <= pend_v_d;
    pend_sub_q  <= pend_sub_d;
    pend_prod_q <= pend_prod_d;
  end

  assign busy = pend_v_q;

  generate
    if (FWD_EN) begin : g_fwd
      assign hi_out = pend_v_q ? acc[ACC_W-1:DATA_W] : hi_q;
      assign lo_out = pend_v_q ? acc[DATA_W-1:0]     : lo_q;
    end else begin : g_no_fwd
      assign hi_out = hi_q;
      assign lo_out = lo_q;
    end
  endgenerate

endmodule

// File: tb/tb_hilo_acc_unit.sv
// Bench for hilo_acc_unit: a forwarding and a non-forwarding instance share
// stimulus; directed vector table first, then randomized cycles vs a model.
module tb_hilo_acc_unit;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [2:0]  op;
  logic [31:0] hi_in, lo_in;
  logic [63:0] prod;
  logic [31:0] hi_f, lo_f, hi_c, lo_c;
  logic        busy_f, busy_c;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  hilo_acc_unit #(.DATA_W(32), .FWD_EN(1'b1)) dut_fwd (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .op(op),
    .hi_in(hi_in), .lo_in(lo_in), .prod(prod),
    .hi_out(hi_f), .lo_out(lo_f), .busy(busy_f)
  );

  hilo_acc_unit #(.DATA_W(32), .FWD_EN(1'b0)) dut_com (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .op(op),
    .hi_in(hi_in), .lo_in(lo_in), .prod(prod),
    .hi_out(hi_c), .lo_out(lo_c), .busy(busy_c)
  );

  typedef struct {
    logic        rst, stall, flush;
    logic [2:0]  op;
    logic [31:0] hi_in, lo_in;
    logic [63:0] prod;
    logic [31:0] e_hi_f, e_lo_f, e_hi_c, e_lo_c;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  typedef struct {
    bit          sub;
    logic [63:0] prod;
  } acc_t;

  logic [63:0] m_val;
  acc_t        m_pend[$];

  task automatic add(input logic r, input logic s, input logic f, input logic [2:0] o,
                     input logic [31:0] hi, input logic [31:0] lo, input logic [63:0] p,
                     input logic [31:0] ehf, input logic [31:0] elf,
                     input logic [31:0] ehc, input logic [31:0] elc, input logic eb);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = f; v.op = o;
    v.hi_in = hi; v.lo_in = lo; v.prod = p;
    v.e_hi_f = ehf; v.e_lo_f = elf; v.e_hi_c = ehc; v.e_lo_c = elc; v.e_busy = eb;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [63:0] got,
                       input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0d: got %h expected %h", name, idx, got, exp);
  endtask

  task automatic drive(input logic r, input logic s, input logic f, input logic [2:0] o,
                       input logic [31:0] hi, input logic [31:0] lo, input logic [63:0] p);
    rst = r; stall = s; flush = f; op = o; hi_in = hi; lo_in = lo; prod = p;
  endtask

  // Reference: architectural {HI,LO} plus a queue of not-yet-committed accumulates.
  task automatic model_step();
    if (rst) begin
      m_val = '0;
      m_pend.delete();
    end else if (flush) begin
      m_pend.delete();
    end else if (!stall) begin
      if (m_pend.size() > 0) begin
        m_val = m_pend[0].sub ? m_val - m_pend[0].prod : m_val + m_pend[0].prod;
        m_pend.delete();
      end
      case (op)
        3'd1: m_val[63:32] = hi_in;
        3'd2: m_val[31:0]  = lo_in;
        3'd3: m_val = {hi_in, lo_in};
        3'd4: m_pend.push_back('{sub: 1'b0, prod: prod});
        3'd5: m_pend.push_back('{sub: 1'b1, prod: prod});
        default: ;
      endcase
    end
  endtask

  function automatic logic [63:0] model_fwd();
    if (m_pend.size() == 0) return m_val;
    return m_pend[0].sub ? m_val - m_pend[0].prod : m_val + m_pend[0].prod;
  endfunction

  initial begin
    logic [63:0] ef;
    drive(1'b1, 1'b0, 1'b0, 3'd0, '0, '0, '0);

    //   rst  stl  fls  op    hi_in         lo_in         prod                 hi_f          lo_f          hi_c          lo_c          busy
    add(1'b1,1'b0,1'b0,3'd0,32'h0,        32'h0,        64'h0,            32'h0,        32'h0,        32'h0,        32'h0,        1'b0);
    add(1'b0,1'b0,1'b0,3'd3,32'h12345678, 32'h9ABCDEF0, 64'h0,            32'h12345678, 32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0, 1'b0);
    add(1'b0,1'b0,1'b0,3'd3,32'h0,        32'hFFFFFFFF, 64'h0,            32'h0,        32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF, 1'b0);
    add(1'b0,1'b0,1'b0,3'd4,32'h0,        32'h0,        64'h1,            32'h1,        32'h0,        32'h0,        32'hFFFFFFFF, 1'b1);
    add(1'b0,1'b0,1'b0,3'd0,32'h0,        32'h0,        64'h0,            32'h1,        32'h0,        32'h1,        32'h0,        1'b0);
    add(1'b1,1'b0,1'b0,3'd0,32'h0,        32'h0,        64'h0,            32'h0,        32'h0,        32'h0,        32'h0,        1'b0);
    add(1'b0,1'b0,1'b0,3'd5,32'h0,        32'h0,        64'h1,            32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        1'b1);
    add(1'b0,1'b0,1'b0,3'd0,32'h0,        32'h0,        64'h0,            32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    add(1'b1,1'b0,1'b0,3'd0,32'h0,        32'h0,        64'h0,            32'h0,        32'h0,        32'h0,        32'h0,        1'b0);
    add(1'b0,1'b0,1'b0,3'd4,32'h0,        32'h0,        64'h5,            32'h0,        32'h5,        32'h0,        32'h0,        1'b1);
    add(1'b0,1'b0,1'b0,3'd4,32'h0,        32'h0,        64'h5,            32'h0,        32'hA,        32'h0,        32'h5,        1'b1);
    add(1'b0,1'b0,1'b0,3'd4,32'h0,        32'h0,        64'h1_00000003,   32'h1,        32'hD,        32'h0,        32'hA,        1'b1);
    add(1'b0,1'b0,1'b0,3'd2,32'hDEAD,     32'h7,        64'h0,            32'h1,        32'h7,        32'h1,        32'h7,        1'b0);
    add(1'b1,1'b0,1'b0,3'd0,32'h0,        32'h0,        64'h0,            32'h0,        32'h0,        32'h0,        32'h0,        1'b0);
    add(1'b0,1'b0,1'b0,3'd4,32'h0,        32'h0,        64'h9,            32'h0,        32'h9,        32'h0,        32'h0,        1'b1);
    add(1'b0,1'b1,1'b0,3'd3,32'hAAAA,     32'hBBBB,     64'h0,            32'h0,        32'h9,        32'h0,        32'h0,        1'b1);
    add(1'b0,1'b1,1'b0,3'd4,32'h0,        32'h0,        64'h77,           32'h0,        32'h9,        32'h0,        32'h0,        1'b1);
    add(1'b0,1'b1,1'b0,3'd0,32'h0,        32'h0,        64'h0,            32'h0,        32'h9,        32'h0,        32'h0,        1'b1);
    add(1'b0,1'b0,1'b0,3'd0,32'h0,        32'h0,        64'h0,            32'h0,        32'h9,        32'h0,        32'h9,        1'b0);
    add(1'b0,1'b0,1'b0,3'd4,32'h0,        32'h0,        64'h9,            32'h0,        32'h12,       32'h0,        32'h9,        1'b1);
    add(1'b0,1'b0,1'b1,3'd4,32'h0,        32'h0,        64'h3,            32'h0,        32'h9,        32'h0,        32'h9,        1'b0);
    add(1'b0,1'b0,1'b0,3'd0,32'h0,        32'h0,        64'h0,            32'h0,        32'h9,        32'h0,        32'h9,        1'b0);
    add(1'b1,1'b0,1'b0,3'd0,32'h0,        32'h0,        64'h0,            32'h0,        32'h0,        32'h0,        32'h0,        1'b0);
    add(1'b0,1'b0,1'b0,3'd4,32'h0,        32'h0,        64'h2,            32'h0,        32'h2,        32'h0,        32'h0,        1'b1);
    add(1'b0,1'b0,1'b0,3'd0,32'h0,        32'h0,        64'h0,            32'h0,        32'h2,        32'h0,        32'h2,        1'b0);
    add(1'b0,1'b0,1'b0,3'd4,32'h0,        32'h0,        64'h2,            32'h0,        32'h4,        32'h0,        32'h2,        1'b1);
    add(1'b1,1'b0,1'b0,3'd3,32'h55,       32'h66,       64'h0,            32'h0,        32'h0,        32'h0,        32'h0,        1'b0);
    add(1'b0,1'b0,1'b0,3'd0,32'h0,        32'h0,        64'h0,            32'h0,        32'h0,        32'h0,        32'h0,        1'b0);
    add(1'b0,1'b0,1'b0,3'd4,32'h0,        32'h0,        64'h6,            32'h0,        32'h6,        32'h0,        32'h0,        1'b1);
    add(1'b0,1'b1,1'b1,3'd0,32'h0,        32'h0,        64'h0,            32'h0,        32'h0,        32'h0,        32'h0,        1'b0);
    add(1'b0,1'b0,1'b0,3'd3,32'h5,        32'h6,        64'h0,            32'h5,        32'h6,        32'h5,        32'h6,        1'b0);
    add(1'b0,1'b0,1'b0,3'd7,32'h8,        32'h9,        64'h4,            32'h5,        32'h6,        32'h5,        32'h6,        1'b0);
    add(1'b1,1'b1,1'b0,3'd0,32'h0,        32'h0,        64'h0,            32'h0,        32'h0,        32'h0,        32'h0,        1'b0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].op,
            vecs[i].hi_in, vecs[i].lo_in, vecs[i].prod);
      @(posedge clk);
      #1;
      $display("vec %0d: op=%0d rst=%0b stall=%0b flush=%0b -> fwd %h_%h com %h_%h busy %0b/%0b",
               i, op, rst, stall, flush, hi_f, lo_f, hi_c, lo_c, busy_f, busy_c);
      check("vec_hi_fwd", i, hi_f, vecs[i].e_hi_f);
      check("vec_lo_fwd", i, lo_f, vecs[i].e_lo_f);
      check("vec_hi_com", i, hi_c, vecs[i].e_hi_c);
      check("vec_lo_com", i, lo_c, vecs[i].e_lo_c);
      check("vec_busy_fwd", i, busy_f, vecs[i].e_busy);
      check("vec_busy_com", i, busy_c, vecs[i].e_busy);
    end

    m_val = '0;
    m_pend.delete();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 15,
            $urandom_range(0, 99) < 8, 3'($urandom_range(0, 7)),
            $urandom, $urandom, {$urandom, $urandom});
      model_step();
      @(posedge clk);
      #1;
      ef = model_fwd();
      $display("rnd %0d: op=%0d rst=%0b stall=%0b flush=%0b -> fwd %h_%h com %h_%h busy %0b",
               i, op, rst, stall, flush, hi_f, lo_f, hi_c, lo_c, busy_f);
      check("rnd_fwd", i, {hi_f, lo_f}, ef);
      check("rnd_com", i, {hi_c, lo_c}, m_val);
      check("rnd_busy_fwd", i, busy_f, m_pend.size() > 0);
      check("rnd_busy_com", i, busy_c, m_pend.size() > 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hilo_acc_unit.md
# hilo_acc_unit

Parametrised HI/LO special-register unit for the multiply/divide path of the CPU core. It holds the architectural HI and LO registers. It supports direct writes (MTHI, MTLO, and full MULT/DIV result writes) and a two-cycle pipelined accumulate (MADD/MSUB family) on the concatenated {HI,LO} value. It sits between the execute-stage multiplier/divider and the register-read path, and exposes stall, flush and busy signals for pipeline hazard control.

## Interface
- DATA_W, 32, width of each of HI and LO; the accumulator is 2*DATA_W bits.
- FWD_EN, 1, when 1, hi_out/lo_out forward an in-flight accumulate result; when 0, they show committed registers only.
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- stall  input  1  freezes all state; op is ignored.
- flush  input  1  cancels any pending accumulate; op is ignored this cycle.
- op  input  3  000 none, 001 write HI, 010 write LO, 011 write both, 100 accumulate add, 101 accumulate subtract, 110/111 treated as none.
- hi_in  input  DATA_W  HI write data (ops 001, 011).
- lo_in  input  DATA_W  LO write data (ops 010, 011).
- prod  input  2*DATA_W  product for accumulate ops, already signed- or zero-extended by the multiplier.
- hi_out  output  DATA_W  HI read value.
- lo_out  output  DATA_W  LO read value.
- busy  output  1  an accumulate is pending and not yet committed.

## Operation
- State:
  - hi_q and lo_q, each DATA_W bits.
  - Pending stage: pend_v (1 bit), pend_sub (1 bit), pend_prod (2*DATA_W bits).
- Priority per cycle: rst > flush > stall > normal.
- rst:
  - hi_q, lo_q, pend_v, pend_sub and pend_prod are all cleared to 0.
  - Outputs read 0 and busy=0 in the following cycle.
- flush:
  - pend_v is cleared with no commit.
  - op is ignored; hi_q and lo_q are unchanged.
- stall (without flush or rst):
  - All registers hold.
  - A pending accumulate does not commit; busy stays asserted.
- Normal cycle, evaluated in this order:
  1. Commit. If pend_v=1, compute acc = {hi_q,lo_q} + pend_prod, or {hi_q,lo_q} - pend_prod when pend_sub=1. The result is modulo 2^(2*DATA_W), with no overflow flag or trap. acc[2W-1:W] is written to hi_q and acc[W-1:0] to lo_q.
  2. Direct write. Ops 001/010/011 write hi_in and/or lo_in to the selected half. A direct write is younger than a committing accumulate, so it overrides only the half it selects; the other half keeps the commit result.
  3. Capture. Ops 100/101 set pend_v=1, pend_sub=op[0] and pend_prod=prod. Otherwise pend_v=0 after any commit.
- Back-to-back accumulates are allowed with no bubble. The second one captures while the first one commits, and its own commit uses the updated hi_q/lo_q.
- busy = pend_v.
- Read path:
  - FWD_EN=1: hi_out/lo_out show acc when pend_v=1, and hi_q/lo_q otherwise (combinational from registered state only).
  - FWD_EN=0: hi_out/lo_out always show hi_q/lo_q.

## Timing
- Direct write issued in cycle N (no stall/flush): visible on hi_out/lo_out from cycle N+1.
- Accumulate issued in cycle N:
  - busy=1 in cycle N+1.
  - Commit happens at the end of N+1; busy=0 in N+2 unless another accumulate was issued in N+1.
  - The result is visible on outputs from N+1 when FWD_EN=1, and from N+2 when FWD_EN=0.
- Each stall cycle during N+1 delays the commit by one cycle; forwarded outputs remain stable throughout.
- flush in N+1 drops the accumulate: hi_q/lo_q keep their pre-issue values and busy=0 from N+2.
- rst in any cycle, including mid-accumulate: no commit occurs and all outputs are 0 from the next cycle.
- No combinational path from op, hi_in, lo_in or prod to any output.

## Test plan
- Reset then read: after rst, hi_out=0, lo_out=0, busy=0. Apply op=011, hi_in=0x1234_5678, lo_in=0x9ABC_DEF0 -> the next cycle reads exactly these values.
- Accumulate with carry (FWD_EN=1): start from HI=0, LO=0xFFFF_FFFF; op=100, prod=1 -> busy=1 and outputs read HI=1, LO=0 in N+1; committed with busy=0 in N+2.
- Subtract with wrap: start from {HI,LO}=0; op=101, prod=1 -> HI=LO=0xFFFF_FFFF after commit.
- Back-to-back and override:
  - Two op=100 with prod=5 from zero -> LO=10, with busy held for two cycles.
  - Then an accumulate (prod=0x1_0000_0003) committing in the same cycle as op=010 with lo_in=7 -> HI=1, LO=7.
- Stall and flush:
  - op=100 with prod=9, then stall=1 for 3 cycles -> busy stays 1, LO unchanged until the stall drops, then LO=9.
  - Repeat with flush in N+1 -> LO stays 9 and busy=0.
- FWD_EN=0 variant, op=100 with prod=2 from zero -> lo_out=0 in N+1 and lo_out=2 in N+2. Also apply rst during N+1 -> outputs are 0 and no commit occurs.
